audio_cic_decimator: RTL and testbench

- Decimating CIC filter upstream of the WM8731 serializer.
- Takes the demodulated 16-bit audio stream at R×32 kHz (default 256 kHz, qualified by in_en) and produces 16-bit audio at 32 kHz.
- Output register audio_dat drives the serializer's audio_dat input directly. The serializer samples it on en32k.
- in_en and en32k are both derived from the 240 MHz clk. R in_en strobes occur per en32k period.

---
 rtl/audio_cic_decimator.sv | 104 ++++++++++
 tb/tb_audio_cic_decimator.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/audio_cic_decimator.sv
// rtl/audio_cic_decimator.sv - N-stage CIC decimator (R = 2**LOG2R, M = 1) with round-half-up and saturation.
module audio_cic_decimator #(
  parameter int IW    = 16,
  parameter int OW    = 16,
  parameter int N     = 3,
  parameter int LOG2R = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_en,
  input  logic signed [IW-1:0] in_dat,
  output logic signed [OW-1:0] audio_dat,
  output logic                 out_stb
);

  localparam int GW = IW + N*LOG2R;
  localparam int S  = N*LOG2R;
  localparam int YW = GW - S + 1;
  localparam logic [GW:0]            HALF     = (GW+1)'(1) << (S-1);
  localparam logic signed [YW-1:0]   Y_MAX    = YW'((2**(OW-1)) - 1);
  localparam logic signed [YW-1:0]   Y_MIN    = ~Y_MAX;
  localparam logic [LOG2R-1:0]       CNT_LAST = '1;

  logic [GW-1:0]        integ_q [N];
  logic [GW-1:0]        integ_d [N];
  logic [GW-1:0]        dly_q   [N];
  logic [GW-1:0]        dly_d   [N];
  logic [GW-1:0]        comb    [N+1];
  logic [LOG2R-1:0]     cnt_q, cnt_d;
  logic                 dec_stb_q, dec_stb_d;
  logic                 out_stb_q, out_stb_d;
  logic signed [OW-1:0] audio_q, audio_d;
  logic signed [GW:0]   rnd;
  logic signed [YW-1:0] y;

  // Integrators chain through their new values so all stages advance in one strobe.
  always_comb begin
    integ_d   = integ_q;
    cnt_d     = cnt_q;
    dec_stb_d = 1'b0;
    if (in_en) begin
      integ_d[0] = integ_q[0] + {{(GW-IW){in_dat[IW-1]}}, in_dat};
      for (int k = 1; k < N; k++) begin
        integ_d[k] = integ_q[k] + integ_d[k-1];
      end
      cnt_d     = cnt_q + 1'b1;
      dec_stb_d = (cnt_q == CNT_LAST);
    end
  end

  always_comb begin
    comb[0] = integ_q[N-1];
    for (int j = 1; j <= N; j++) begin
      comb[j] = comb[j-1] - dly_q[j-1];
    end
    dly_d = dly_q;
    if (dec_stb_q) begin
      for (int j = 0; j < N; j++) begin
        dly_d[j] = comb[j];
      end
    end
  end

  // One spare bit keeps the rounding offset from wrapping at positive full scale.
  always_comb begin
    rnd       = $signed({comb[N][GW-1], comb[N]} + HALF);
    y         = YW'(rnd >>> S);
    audio_d   = audio_q;
    out_stb_d = dec_stb_q;
    if (dec_stb_q) begin
      if (y > Y_MAX) begin
        audio_d = Y_MAX[OW-1:0];
      end else if (y < Y_MIN) begin
        audio_d = Y_MIN[OW-1:0];
      end else begin
        audio_d = y[OW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < N; k++) begin
        integ_q[k] <= '0;
        dly_q[k]   <= '0;
      end
      cnt_q     <= '0;
      dec_stb_q <= 1'b0;
      out_stb_q <= 1'b0;
      audio_q   <= '0;
    end else begin
      integ_q   <= integ_d;
      dly_q     <= dly_d;
      cnt_q     <= cnt_d;
      dec_stb_q <= dec_stb_d;
      out_stb_q <= out_stb_d;
      audio_q   <= audio_d;
    end
  end

  assign audio_dat = audio_q;
  assign out_stb   = out_stb_q;

endmodule

// File: tb/tb_audio_cic_decimator.sv
// tb/tb_audio_cic_decimator.sv - directed and model-based checks for audio_cic_decimator.
module tb_audio_cic_decimator;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               in_en = 1'b0;
  logic signed [15:0] in_dat = '0;
  logic signed [15:0] audio_dat;
  logic               out_stb;

  audio_cic_decimator dut (
    .clk       (clk),
    .reset     (reset),
    .in_en     (in_en),
    .in_dat    (in_dat),
    .audio_dat (audio_dat),
    .out_stb   (out_stb)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  int cyc    = 0;
  int en_cnt = 0;
  int last_t = -1;
  int got_q[$];
  int stamp_q[$];
  int xs[$];
  longint h[22];

  // Outputs reflect the previous edge; inputs are those about to be sampled.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      en_cnt = 0;
      last_t = -1;
    end else begin
      if (out_stb) begin
        if (last_t >= 0) chk("stb_latency", cyc - last_t, 2);
        else             chk("stale_stb", 1, 0);
        last_t = -1;
        got_q.push_back(int'(audio_dat));
        stamp_q.push_back(cyc);
      end
      if (in_en) begin
        if (en_cnt % 8 == 7) last_t = cyc;
        en_cnt++;
        xs.push_back(int'(in_dat));
      end
    end
  end

  function automatic int val(input int mode, input int v, input int k);
    case (mode)
      0:       return v;
      1:       return (k % 2 == 1) ? -v : v;
      2:       return int'($urandom_range(0, 65535)) - 32768;
      default: return ($urandom_range(0, 1) == 1) ? 32767 : -32768;
    endcase
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    in_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    got_q.delete();
    stamp_q.delete();
    xs.delete();
  endtask

  task automatic drive(input int n, input int gap, input int mode, input int v);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      in_en  = 1'b1;
      in_dat = 16'(val(mode, v, k));
      for (int g = 1; g < gap; g++) begin
        @(posedge clk); #1;
        in_en  = 1'b0;
        in_dat = 16'($urandom);
      end
    end
    @(posedge clk); #1;
    in_en = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic model_cmp(input string tag);
    int n;
    longint acc, y;
    n = xs.size() / 8;
    chk({tag, "_count"}, got_q.size(), n);
    for (int m = 0; m < n && m < got_q.size(); m++) begin
      acc = 0;
      for (int k = 0; k < 22; k++) begin
        if (8*m + 7 - k >= 0) acc += h[k] * longint'(xs[8*m + 7 - k]);
      end
      y = (acc + 256) >>> 9;
      if (y > 32767)  y = 32767;
      if (y < -32768) y = -32768;
      chk(tag, got_q[m], y);
    end
  endtask

  task automatic steady(input string tag, input int from, input int exp);
    for (int m = from; m < got_q.size(); m++) chk(tag, got_q[m], exp);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    longint h2[15];
    int dc[5];
    dc = '{120, 456, 512, 512, 512};
    for (int i = 0; i < 15; i++) h2[i] = 0;
    for (int i = 0; i < 22; i++) h[i] = 0;
    for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) h2[i+j] += 1;
    for (int i = 0; i < 15; i++) for (int j = 0; j < 8; j++) h[i+j] += h2[i];

    reset  = 1'b0;
    in_dat = 16'sd512;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      in_en = ~in_en;
      @(negedge clk);
      chk("rst_audio", audio_dat, 0);
      chk("rst_stb", out_stb, 0);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    in_en = 1'b0;
    got_q.delete(); stamp_q.delete(); xs.delete();

    drive(40, 15, 0, 512);
    chk("dc_count", got_q.size(), 5);
    for (int m = 0; m < 5 && m < got_q.size(); m++) chk("dc_seq", got_q[m], dc[m]);

    do_reset();
    drive(21, 15, 0, 512);
    chk("mid_pre_count", got_q.size(), 2);
    do_reset();
    drive(24, 15, 0, 512);
    chk("mid_post_count", got_q.size(), 3);
    for (int m = 0; m < 3 && m < got_q.size(); m++) chk("mid_post_seq", got_q[m], dc[m]);

    do_reset();
    drive(48, 3, 0, 32767);
    steady("pos_fs", 2, 32767);
    model_cmp("pos_fs_model");

    do_reset();
    drive(48, 3, 0, -32768);
    steady("neg_fs", 2, -32768);
    model_cmp("neg_fs_model");

    do_reset();
    drive(48, 2, 1, 16384);
    steady("nyquist", 2, 0);
    model_cmp("nyquist_model");

    do_reset();
    drive(10000, 1, 2, 0);
    model_cmp("b2b_rand");
    for (int m = 1; m < stamp_q.size(); m++) chk("b2b_period", stamp_q[m] - stamp_q[m-1], 8);

    do_reset();
    drive(8000, 1, 3, 0);
    model_cmp("extremes");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
